// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract around one shared full-adder cell; result WIDTH+1 cycles after start.
// start is only honoured in IDLE or DONE; requests while busy are dropped, not queued.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  serial_fa u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      part      <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B once at capture, force carry-in.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          part  <= {fa_s, part[WIDTH-1:1]};
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 2))
            carry_msb <= fa_co;
          // Overflow compares the carry into the MSB with the carry out of it.
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {fa_s, part[WIDTH-1:1]};
            cout  <= fa_co;
            ovf   <= fa_co ^ carry_msb;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: expected results queued at start, checked on each done pulse.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int           n_vec;
  int           n_err;
  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_sum;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] yv;
    logic [W:0]   t;
    exp_t         e;
    yv  = sb ? ~y : y;
    t   = {1'b0, x} + {1'b0, yv} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == yv[W-1]) && (e.s[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Results are scored on every done pulse, whichever test launched them.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'(0));
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum",  32'(sum),  32'(mon_e.s));
        chk("cout", 32'(cout), 32'(mon_e.c));
        chk("ovf",  32'(ovf),  32'(mon_e.v));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input bit settle);
    exp_t e;
    e = model(x, y, ci, sb);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    sb_q.push_back(e);
    tick;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      chk("busy_run",  32'(busy), 32'(1));
      chk("done_early", 32'(done), 32'(0));
      chk("sum_hold",  32'(sum),  32'(last_sum));
      tick;
    end
    chk("busy_end", 32'(busy), 32'(0));
    chk("done_on",  32'(done), 32'(1));
    last_sum = e.s;
    if (settle) begin
      tick;
      chk("done_pulse", 32'(done), 32'(0));
      chk("sum_keep",   32'(sum),  32'(e.s));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; last_sum = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum",  32'(sum),  32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf",  32'(ovf),  32'(0));
    tick; tick;
    rst = 1'b0;
    tick;

    // Directed arithmetic vectors with literal expectations.
    run_op(8'h3C, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("v1_sum", 32'(sum), 32'h91); chk("v1_cout", 32'(cout), 32'(0)); chk("v1_ovf", 32'(ovf), 32'(1));
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("v2_sum", 32'(sum), 32'h00); chk("v2_cout", 32'(cout), 32'(1)); chk("v2_ovf", 32'(ovf), 32'(0));
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("v3_sum", 32'(sum), 32'h80); chk("v3_cout", 32'(cout), 32'(0)); chk("v3_ovf", 32'(ovf), 32'(1));
    run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b1);
    chk("v4_sum", 32'(sum), 32'hF0); chk("v4_cout", 32'(cout), 32'(0)); chk("v4_ovf", 32'(ovf), 32'(0));
    run_op(8'h20, 8'h10, 1'b0, 1'b1, 1'b1);
    chk("v5_sum", 32'(sum), 32'h10); chk("v5_cout", 32'(cout), 32'(1)); chk("v5_ovf", 32'(ovf), 32'(0));

    // Start held through RUN with changing operands, then restarted in DONE.
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
    tick;
    for (int k = 0; k < W; k++) begin
      chk("hs_busy", 32'(busy), 32'(1));
      chk("hs_done", 32'(done), 32'(0));
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      tick;
    end
    chk("hs_done1", 32'(done), 32'(1));
    chk("hs_sum1",  32'(sum),  32'h33);
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
    sb_q.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
    tick;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk("b2b_busy", 32'(busy), 32'(1));
      chk("b2b_done", 32'(done), 32'(0));
      chk("b2b_hold", 32'(sum),  32'h33);
      tick;
    end
    chk("b2b_done2", 32'(done), 32'(1));
    chk("b2b_sum",   32'(sum),  32'h03);
    tick;
    chk("b2b_idle", 32'(done), 32'(0));
    last_sum = 8'h03;

    // Random operands, mixed add and subtract.
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    // Asynchronous abort mid-operation; no result is expected.
    a = 8'h5A; b = 8'h33; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum",  32'(sum),  32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_ovf",  32'(ovf),  32'(0));
    tick; tick;
    rst = 1'b0;
    last_sum = '0;
    for (int k = 0; k < 10; k++) begin
      chk("abort_nodone", 32'(done), 32'(0));
      tick;
    end
    run_op(8'h0A, 8'h05, 1'b0, 1'b0, 1'b1);
    chk("post_sum", 32'(sum), 32'h0F);

    tick;
    chk("scb_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
